dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory end of the core's load/store request interface.
//  Accepts one MEM-stage request at a time and holds it for WAIT_CYCLES wait states.
//  Performs the byte/half/word store or sign/zero-extended load selected by funct3.
//  Returns a response on a valid/ready channel; the load result feeds WB_WR_MUX_MEM.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; byte address range 0 .. 4*DEPTH_WORDS-1
//  WAIT_CYCLES  2     wait states between request accept and response (0..15)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_we      in   1   1 = store (OPCODE_STORE), 0 = load (OPCODE_LOAD)
//  req_funct3  in   3   RISC-V funct3 of the LOAD/STORE instruction
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (rs2)
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   core accepts the response
//  rsp_rdata   out  32  extended load data; 0 for stores and errors
//  rsp_err     out  1   access fault: bad funct3, out of range, or misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 on the first cycle after rst deasserts.
//    rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory array is not cleared.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    * IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata.
//      Go to WAIT; go directly to RESP when WAIT_CYCLES==0.
//    * WAIT: req_ready=0. Counter counts 1..WAIT_CYCLES; at WAIT_CYCLES go to RESP.
//    * RESP: rsp_valid=1, and rdata/err stay stable until rsp_ready.
//      On rsp_valid&&rsp_ready go to IDLE. No new accept in the handshake cycle.
//  - Latency: request accept edge to rsp_valid high = WAIT_CYCLES+1 cycles.
//    Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
//  - Store commit: the array is written on the edge entering RESP, and only when err=0.
//    funct3 000 SB writes byte addr[1:0] = wdata[7:0].
//    funct3 001 SH writes half addr[1] = wdata[15:0].
//    funct3 010 SW writes the full word. Other bytes are unchanged.
//  - Load: word read at addr[31:2]; the selected lane is extended.
//    000 LB sign-8, 001 LH sign-16, 010 LW, 100 LBU zero-8, 101 LHU zero-16.
//  - Errors (rsp_err=1, rsp_rdata=0, no array write):
//    * funct3 in {011,110,111};
//    * store with funct3[2]=1;
//    * addr >= 4*DEPTH_WORDS.
//  - Back-to-back: a store then a load to the same address returns the stored data.
//  - Reset mid-operation (WAIT or RESP): return to IDLE and drop the response.
//    A store still in WAIT is not committed; a store already in RESP stays committed.
//  - Inputs are ignored outside IDLE. The captured request is immune to input changes.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//    LH/LHU/SH with addr[0]!=0 -> rsp_err=1.
//    LW/SW with addr[1:0]!=0   -> rsp_err=1.
//    No write, rdata=0.
//  DMEM_MISALIGN_TRAP_EN undefined:
//    Low address bits below the access size are forced to 0 (silent alignment).
//    No misalignment error is raised.
// TESTING
//  1. rst 3 cycles, then idle -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  2. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (WAIT_CYCLES=2)
//     -> rsp_valid 3 cycles after each accept; rdata 0xDEADBEEF, err=0.
//  3. SB 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080;
//     LW 0x10 -> 0xDEAD80EF.
//  4. rsp_ready held 0 for 5 cycles in RESP
//     -> rsp_valid, rdata and err stable; req_ready=0; a second req_valid is not accepted.
//  5. LW addr 0x12 -> with DMEM_MISALIGN_TRAP_EN: err=1, rdata=0; without: rdata=0xDEAD80EF.
//     LW addr 0x1000 (DEPTH 1024) -> err=1. funct3 011 -> err=1.
//  6. SW 0x20 data 0x12345678, rst pulsed in WAIT -> IDLE next cycle, no rsp_valid;
//     LW 0x20 returns the previous contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store request at a time, WAIT_CYCLES wait states, valid/ready response.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being silently aligned.
//
// state | meaning
// IDLE  | req_ready=1, capture request on req_valid
// WAIT  | counting wait states 1..WAIT_CYCLES
// RESP  | rsp_valid=1, hold rdata/err until rsp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // In IDLE the request is still on the inputs; later the captured copy is used.
  logic        idle;
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, load_v, wd;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;
  logic        err_c, mis_bad, capture, enter_resp, commit;

  assign idle      = (state_q == IDLE);
  assign cur_we    = idle ? req_we     : we_q;
  assign cur_f3    = idle ? req_funct3 : f3_q;
  assign cur_addr  = idle ? req_addr   : addr_q;
  assign cur_wdata = idle ? req_wdata  : wdata_q;

  assign idx     = cur_addr[AW+1:2];
  assign rd_word = mem_q[idx];
  assign byte_v  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign half_v  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    mis_bad = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (cur_f3[1:0])
      2'b01:   mis_bad = cur_addr[0];
      2'b10:   mis_bad = (cur_addr[1:0] != 2'b00);
      default: mis_bad = 1'b0;
    endcase
`endif
    err_c = (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11) || (cur_we && cur_f3[2])
            || (cur_addr >= ADDR_LIMIT) || mis_bad;
  end

  // Sub-size low address bits never reach a lane select, so alignment is implicit.
  always_comb begin
    load_v = 32'd0;
    wd     = cur_wdata;
    be     = 4'b0000;
    case (cur_f3)
      3'b000: begin
        load_v = {{24{byte_v[7]}}, byte_v};
        wd     = {4{cur_wdata[7:0]}};
        be     = 4'b0001 << cur_addr[1:0];
      end
      3'b001: begin
        load_v = {{16{half_v[15]}}, half_v};
        wd     = {2{cur_wdata[15:0]}};
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        load_v = rd_word;
        be     = 4'b1111;
      end
      3'b100:  load_v = {24'd0, byte_v};
      3'b101:  load_v = {16'd0, half_v};
      default: load_v = 32'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = err_c;
      rdata_d = (err_c || cur_we) ? 32'd0 : load_v;
    end
  end

  assign commit = enter_resp && cur_we && !err_c && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
